// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and constants for the block-RAM port arbiter.
//   arb_state_t : arbiter FSM states (IDLE -> ISSUE -> WAIT -> DONE -> IDLE)
//   RD_LAT_MAX  : largest supported BRAM read latency
//   CNT_W       : width of the read-latency wait counter
//   id_w(n)     : index width for n requesters, never less than 1
// -----------------------------------------------------------------------------
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    localparam int RD_LAT_MAX = 3;
    localparam int CNT_W      = $clog2(RD_LAT_MAX + 1);

    function automatic int id_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
// Purely combinational round-robin winner selection.
// Optional feature macro: MEM_ARB_PRIO0_EN
//   undefined : scan last+1, last+2, ... modulo NREQ over all requesters
//   defined   : requester 0 wins whenever it requests; otherwise the scan
//               covers requesters 1..NREQ-1 only
// Ports:
//   req    in  [NREQ-1:0]  request bits
//   last   in  [ID_W-1:0]  most recently served requester
//   winner out [ID_W-1:0]  chosen requester (0 when nothing found)
//   found  out             at least one eligible request present
// -----------------------------------------------------------------------------
module rr_picker
    import mem_arb_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int ID_W = id_w(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] last,
    output logic [ID_W-1:0] winner,
    output logic            found
);

    always_comb begin
        int              idx;
        logic [NREQ-1:0] sh;
        logic            eligible;
        winner   = '0;
        found    = 1'b0;
        idx      = 0;
        sh       = '0;
        eligible = 1'b0;
        // k = 1 looks at last+1 first, k = NREQ comes back round to last.
        for (int k = 1; k <= NREQ; k++) begin
            idx = int'(last) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            sh = req >> idx;
`ifdef MEM_ARB_PRIO0_EN
            eligible = sh[0] && (idx != 0);
`else
            eligible = sh[0];
`endif
            if (!found && eligible) begin
                found  = 1'b1;
                winner = ID_W'(idx);
            end
        end
`ifdef MEM_ARB_PRIO0_EN
        // Flash writer overrides the rotation entirely.
        if (req[0]) begin
            found  = 1'b1;
            winner = '0;
        end
`endif
    end

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Serialises NREQ valid/ready requesters onto one single-port BRAM port with
// round-robin fairness and a fixed access latency of RD_LAT+2 cycles from the
// sampling IDLE cycle to the req_ready pulse.
// Optional feature macro: MEM_ARB_PRIO0_EN (strict priority for requester 0,
// pointer left untouched on its grants).
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/addr/wdata/wstrb   per-requester request, packed [i*W +: W]
//   req_ready             one-hot completion pulse
//   req_rdata             shared read data, valid while req_ready != 0
//   grant_id              current / last granted requester
//   busy                  access in flight
//   mem_en/we/addr/wdata  BRAM command (registered)
//   mem_rdata             BRAM read data, RD_LAT cycles after mem_en
// -----------------------------------------------------------------------------
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NREQ   = 3,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NREQ-1:0]            req_valid,
    input  logic [NREQ*ADDR_W-1:0]     req_addr,
    input  logic [NREQ*DATA_W-1:0]     req_wdata,
    input  logic [NREQ*DATA_W/8-1:0]   req_wstrb,
    output logic [NREQ-1:0]            req_ready,
    output logic [DATA_W-1:0]          req_rdata,
    output logic [id_w(NREQ)-1:0]      grant_id,
    output logic                       busy,
    output logic                       mem_en,
    output logic [DATA_W/8-1:0]        mem_we,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [DATA_W-1:0]          mem_wdata,
    input  logic [DATA_W-1:0]          mem_rdata
);

    localparam int ID_W = id_w(NREQ);
    localparam int BE_W = DATA_W / 8;

    arb_state_t         state;
    logic [ID_W-1:0]    last;
    logic [CNT_W-1:0]   wait_cnt;
    logic [ID_W-1:0]    pick;
    logic               found;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_wdata;
    logic [BE_W-1:0]    sel_wstrb;

    rr_picker #(
        .NREQ (NREQ),
        .ID_W (ID_W)
    ) u_picker (
        .req    (req_valid),
        .last   (last),
        .winner (pick),
        .found  (found)
    );

    // Mux the winner's request fields with constant slice indices.
    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_wstrb = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick == ID_W'(i)) begin
                sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = req_wdata[i*DATA_W +: DATA_W];
                sel_wstrb = req_wstrb[i*BE_W +: BE_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            mem_en    <= 1'b0;
            mem_we    <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            req_ready <= '0;
            req_rdata <= '0;
            busy      <= 1'b0;
            grant_id  <= '0;
            last      <= ID_W'(NREQ - 1);
            wait_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // Request fields are captured straight into the BRAM
                    // command registers; nothing is re-sampled after this.
                    if (found) begin
                        grant_id  <= pick;
                        mem_en    <= 1'b1;
                        mem_we    <= sel_wstrb;
                        mem_addr  <= sel_addr;
                        mem_wdata <= sel_wdata;
                        busy      <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    mem_en   <= 1'b0;
                    mem_we   <= '0;
                    wait_cnt <= CNT_W'(RD_LAT - 1);
                    state    <= WAIT;
                end
                WAIT: begin
                    if (wait_cnt == '0) begin
                        req_rdata <= mem_rdata;
                        req_ready <= NREQ'(1) << grant_id;
                        state     <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                DONE: begin
                    req_ready <= '0;
                    busy      <= 1'b0;
`ifdef MEM_ARB_PRIO0_EN
                    if (grant_id != '0) last <= grant_id;
`else
                    last <= grant_id;
`endif
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Directed bench for mem_arbiter (default round-robin build). Instance a uses
// RD_LAT=1, instance b uses RD_LAT=3; each has its own behavioural BRAM with
// read-first behaviour and a preload port driven during reset.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int NREQ = 3;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int BW   = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic [NREQ-1:0]    a_valid, a_ready, b_valid, b_ready;
    logic [NREQ*AW-1:0] a_addr, b_addr;
    logic [NREQ*DW-1:0] a_wdata, b_wdata;
    logic [NREQ*BW-1:0] a_wstrb, b_wstrb;
    logic [DW-1:0]      a_rdata, b_rdata, a_mwdata, b_mwdata, a_mrdata, b_mrdata;
    logic [1:0]         a_gid, b_gid;
    logic               a_busy, b_busy, a_men, b_men;
    logic [BW-1:0]      a_mwe, b_mwe;
    logic [AW-1:0]      a_maddr, b_maddr;

    logic        ld_a, ld_b;
    logic [7:0]  ld_addr;
    logic [31:0] ld_data;

    int checks = 0;
    int errors = 0;

    mem_arbiter #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .req_valid(a_valid), .req_addr(a_addr), .req_wdata(a_wdata), .req_wstrb(a_wstrb),
        .req_ready(a_ready), .req_rdata(a_rdata), .grant_id(a_gid), .busy(a_busy),
        .mem_en(a_men), .mem_we(a_mwe), .mem_addr(a_maddr), .mem_wdata(a_mwdata),
        .mem_rdata(a_mrdata)
    );

    mem_arbiter #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(3)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .req_valid(b_valid), .req_addr(b_addr), .req_wdata(b_wdata), .req_wstrb(b_wstrb),
        .req_ready(b_ready), .req_rdata(b_rdata), .grant_id(b_gid), .busy(b_busy),
        .mem_en(b_men), .mem_we(b_mwe), .mem_addr(b_maddr), .mem_wdata(b_mwdata),
        .mem_rdata(b_mrdata)
    );

    // BRAM model a: read latency 1, read-first.
    logic [31:0] mem_a [256];
    logic [31:0] a_q;
    always @(posedge clk) begin
        if (ld_a) begin
            mem_a[ld_addr] <= ld_data;
        end else if (a_men) begin
            a_q <= mem_a[a_maddr[7:0]];
            for (int i = 0; i < BW; i++)
                if (a_mwe[i]) mem_a[a_maddr[7:0]][i*8 +: 8] <= a_mwdata[i*8 +: 8];
        end
    end
    assign a_mrdata = a_q;

    // BRAM model b: read latency 3, read-only use.
    logic [31:0] mem_b [256];
    logic [31:0] b_p0, b_p1, b_p2;
    always @(posedge clk) begin
        if (ld_b) mem_b[ld_addr] <= ld_data;
        else if (b_men) b_p0 <= mem_b[b_maddr[7:0]];
        b_p1 <= b_p0;
        b_p2 <= b_p1;
    end
    assign b_mrdata = b_p2;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input int i, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [3:0] strb);
        a_addr[i*AW +: AW]  = addr;
        a_wdata[i*DW +: DW] = wd;
        a_wstrb[i*BW +: BW] = strb;
        a_valid[i]          = 1'b1;
    endtask

    task automatic preload(input logic sel_b, input logic [7:0] addr, input logic [31:0] data);
        ld_a    = !sel_b;
        ld_b    = sel_b;
        ld_addr = addr;
        ld_data = data;
        step();
        ld_a = 1'b0;
        ld_b = 1'b0;
    endtask

    task automatic test_reset;
        rst_n   = 1'b0;
        a_valid = '0; a_addr = '0; a_wdata = '0; a_wstrb = '0;
        b_valid = '0; b_addr = '0; b_wdata = '0; b_wstrb = '0;
        ld_a = 1'b0; ld_b = 1'b0; ld_addr = '0; ld_data = '0;
        step(); step();
        preload(1'b0, 8'h10, 32'hDEADBEEF);
        preload(1'b0, 8'h20, 32'hAAAAAAAA);
        preload(1'b0, 8'h30, 32'h11110000);
        preload(1'b0, 8'h31, 32'h22221111);
        preload(1'b0, 8'h32, 32'h33332222);
        preload(1'b1, 8'h10, 32'hCAFEF00D);
        checks++; if (a_ready !== 3'b000) begin errors++; $display("FAIL reset_ready: got %b expected 000", a_ready); end
        checks++; if (a_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", a_rdata); end
        checks++; if (a_gid !== 2'd0) begin errors++; $display("FAIL reset_grant: got %0d expected 0", a_gid); end
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", a_busy); end
        checks++; if (a_men !== 1'b0) begin errors++; $display("FAIL reset_mem_en: got %b expected 0", a_men); end
        checks++; if (a_mwe !== 4'h0) begin errors++; $display("FAIL reset_mem_we: got %b expected 0000", a_mwe); end
        checks++; if (a_maddr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr: got %h expected 0", a_maddr); end
        checks++; if (a_mwdata !== 32'h0) begin errors++; $display("FAIL reset_mem_wdata: got %h expected 0", a_mwdata); end
        checks++; if ({b_ready, b_busy, b_men, b_gid, b_mwe} !== 12'h0) begin errors++;
            $display("FAIL reset_b_ctrl: got %h expected 000", {b_ready, b_busy, b_men, b_gid, b_mwe}); end
        checks++; if ({b_rdata, b_maddr, b_mwdata} !== 96'h0) begin errors++;
            $display("FAIL reset_b_data: got %h expected 0", {b_rdata, b_maddr, b_mwdata}); end
        rst_n = 1'b1;
    endtask

    task automatic test_single_read;
        set_a(1, 32'h10, 32'h0, 4'h0);
        step();
        checks++; if (a_men !== 1'b1) begin errors++; $display("FAIL rd_mem_en: got %b expected 1", a_men); end
        checks++; if (a_maddr !== 32'h10) begin errors++; $display("FAIL rd_mem_addr: got %h expected 10", a_maddr); end
        checks++; if (a_mwe !== 4'h0) begin errors++; $display("FAIL rd_mem_we: got %b expected 0000", a_mwe); end
        checks++; if (a_gid !== 2'd1) begin errors++; $display("FAIL rd_grant: got %0d expected 1", a_gid); end
        checks++; if (a_busy !== 1'b1) begin errors++; $display("FAIL rd_busy: got %b expected 1", a_busy); end
        checks++; if (a_ready !== 3'b000) begin errors++; $display("FAIL rd_early_ready_t1: got %b expected 000", a_ready); end
        step();
        checks++; if (a_men !== 1'b0) begin errors++; $display("FAIL rd_mem_en_pulse: got %b expected 0", a_men); end
        checks++; if (a_ready !== 3'b000) begin errors++; $display("FAIL rd_early_ready_t2: got %b expected 000", a_ready); end
        step();
        checks++; if (a_ready !== 3'b010) begin errors++; $display("FAIL rd_ready: got %b expected 010", a_ready); end
        checks++; if (a_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_rdata: got %h expected deadbeef", a_rdata); end
        a_valid = '0;
        step();
        checks++; if (a_ready !== 3'b000) begin errors++; $display("FAIL rd_ready_pulse: got %b expected 000", a_ready); end
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL rd_busy_end: got %b expected 0", a_busy); end
    endtask

    task automatic test_write;
        set_a(2, 32'h20, 32'h12345678, 4'b0011);
        step();
        checks++; if (a_mwe !== 4'b0011) begin errors++; $display("FAIL wr_mem_we: got %b expected 0011", a_mwe); end
        checks++; if (a_mwdata !== 32'h12345678) begin errors++; $display("FAIL wr_mem_wdata: got %h expected 12345678", a_mwdata); end
        checks++; if (a_maddr !== 32'h20) begin errors++; $display("FAIL wr_mem_addr: got %h expected 20", a_maddr); end
        checks++; if (a_gid !== 2'd2) begin errors++; $display("FAIL wr_grant: got %0d expected 2", a_gid); end
        step();
        checks++; if (a_mwe !== 4'b0000) begin errors++; $display("FAIL wr_mem_we_pulse: got %b expected 0000", a_mwe); end
        step();
        checks++; if (a_ready !== 3'b100) begin errors++; $display("FAIL wr_ready: got %b expected 100", a_ready); end
        checks++; if (a_rdata !== 32'hAAAAAAAA) begin errors++; $display("FAIL wr_rdata_rdw: got %h expected aaaaaaaa", a_rdata); end
        a_valid = '0;
        step();
        // Pointer now at 2, so the scan wraps to requester 0.
        set_a(0, 32'h20, 32'h0, 4'h0);
        step();
        checks++; if (a_gid !== 2'd0) begin errors++; $display("FAIL rb_grant: got %0d expected 0", a_gid); end
        step(); step();
        checks++; if (a_ready !== 3'b001) begin errors++; $display("FAIL rb_ready: got %b expected 001", a_ready); end
        checks++; if (a_rdata !== 32'hAAAA5678) begin errors++; $display("FAIL rb_rdata: got %h expected aaaa5678", a_rdata); end
        a_valid = '0;
        step();
    endtask

    task automatic test_round_robin;
        logic [31:0] rr_data [3];
        int          exp_id;
        logic [2:0]  exp_rdy;
        rr_data[0] = 32'h11110000;
        rr_data[1] = 32'h22221111;
        rr_data[2] = 32'h33332222;
        rst_n = 1'b0;
        step(); step();
        rst_n = 1'b1;
        for (int i = 0; i < NREQ; i++) set_a(i, 32'h30 + 32'(i), 32'h0, 4'h0);
        for (int n = 0; n < 6; n++) begin
            exp_id  = n % 3;
            exp_rdy = 3'b001 << exp_id;
            step();
            checks++; if (a_men !== 1'b1 || a_gid !== 2'(exp_id)) begin errors++;
                $display("FAIL rr_grant[%0d]: got en=%b id=%0d expected en=1 id=%0d", n, a_men, a_gid, exp_id); end
            step(); step();
            checks++; if (a_ready !== exp_rdy || a_rdata !== rr_data[exp_id]) begin errors++;
                $display("FAIL rr_done[%0d]: got ready=%b data=%h expected ready=%b data=%h",
                         n, a_ready, a_rdata, exp_rdy, rr_data[exp_id]); end
            step();
            checks++; if (a_men !== 1'b0 || a_ready !== 3'b000) begin errors++;
                $display("FAIL rr_idle_gap[%0d]: got en=%b ready=%b expected en=0 ready=000", n, a_men, a_ready); end
        end
        a_valid = '0;
        step(); step(); step();
    endtask

    task automatic test_rd_lat3;
        b_addr[0 +: AW] = 32'h10;
        b_wstrb[0 +: BW] = 4'h0;
        b_valid = 3'b001;
        step();
        checks++; if (b_men !== 1'b1 || b_maddr !== 32'h10) begin errors++;
            $display("FAIL l3_issue: got en=%b addr=%h expected en=1 addr=10", b_men, b_maddr); end
        for (int c = 2; c <= 4; c++) begin
            step();
            checks++; if (b_ready !== 3'b000) begin errors++;
                $display("FAIL l3_early_ready_t%0d: got %b expected 000", c, b_ready); end
        end
        step();
        checks++; if (b_ready !== 3'b001) begin errors++; $display("FAIL l3_ready: got %b expected 001", b_ready); end
        checks++; if (b_rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL l3_rdata: got %h expected cafef00d", b_rdata); end
        b_valid = '0;
        step();
        checks++; if (b_ready !== 3'b000) begin errors++; $display("FAIL l3_ready_pulse: got %b expected 000", b_ready); end
    endtask

    task automatic test_reset_during_wait;
        set_a(1, 32'h10, 32'h0, 4'h0);
        step(); step();
        checks++; if (a_busy !== 1'b1) begin errors++; $display("FAIL rw_busy_wait: got %b expected 1", a_busy); end
        rst_n = 1'b0;
        #1;
        checks++; if (a_busy !== 1'b0 || a_gid !== 2'd0 || a_maddr !== 32'h0 || a_men !== 1'b0 || a_ready !== 3'b000) begin
            errors++; $display("FAIL rw_async_clear: got busy=%b id=%0d addr=%h en=%b ready=%b expected all 0",
                               a_busy, a_gid, a_maddr, a_men, a_ready); end
        step(); step();
        checks++; if (a_ready !== 3'b000) begin errors++; $display("FAIL rw_no_ready: got %b expected 000", a_ready); end
        rst_n = 1'b1;
        step();
        checks++; if (a_men !== 1'b1 || a_gid !== 2'd1) begin errors++;
            $display("FAIL rw_reissue: got en=%b id=%0d expected en=1 id=1", a_men, a_gid); end
        step(); step();
        checks++; if (a_ready !== 3'b010 || a_rdata !== 32'hDEADBEEF) begin errors++;
            $display("FAIL rw_done: got ready=%b data=%h expected ready=010 data=deadbeef", a_ready, a_rdata); end
        a_valid = '0;
        step();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_write();
        test_round_robin();
        test_rd_lat3();
        test_reset_during_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates one single-port block-RAM port among `NREQ` word-wide requesters using a valid/ready handshake, for example the UART flash writer, the CPU data/instruction port and a future blitter. It sits between those masters and the program/framebuffer BRAM. It serialises their accesses with round-robin fairness and returns read data with a fixed, known latency.

## Interface
Parameters:
- `NREQ`, 3: number of requesters, 2..8.
- `ADDR_W`, 32: word address width.
- `DATA_W`, 32: data width, multiple of 8.
- `RD_LAT`, 1: BRAM read latency in cycles, 1..3.

Ports (index `i` selects requester `i`; flat vectors are packed as requester `i` at slice `[i*W +: W]`):
- `clk` in 1: single clock, all logic on rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `req_valid` in `NREQ`: request pending; held until the matching `req_ready`.
- `req_addr` in `NREQ*ADDR_W`: word address.
- `req_wdata` in `NREQ*DATA_W`: write data.
- `req_wstrb` in `NREQ*DATA_W/8`: byte write enables; all-zero means read.
- `req_ready` out `NREQ`: one-cycle completion pulse, one-hot.
- `req_rdata` out `DATA_W`: shared read data, valid only while some `req_ready` bit is high.
- `grant_id` out `$clog2(NREQ)`: currently or last granted requester.
- `busy` out 1: access in flight (state ≠ IDLE).
- `mem_en` out 1: BRAM enable, one cycle per access.
- `mem_we` out `DATA_W/8`: BRAM byte write enables.
- `mem_addr` out `ADDR_W`: BRAM address.
- `mem_wdata` out `DATA_W`: BRAM write data.
- `mem_rdata` in `DATA_W`: BRAM read data, valid `RD_LAT` cycles after the `mem_en` cycle.

## Operation
- FSM states: IDLE → ISSUE → WAIT → DONE → IDLE.
- **IDLE**
  - If any `req_valid` is set, pick winner `g`, latch its addr/wdata/wstrb, set `grant_id=g`, go to ISSUE.
  - Otherwise stay in IDLE.
- **ISSUE**
  - `mem_en=1`, `mem_we/mem_addr/mem_wdata` = latched values (registered outputs).
  - Load the wait counter with `RD_LAT-1`, go to WAIT.
- **WAIT**
  - Count down.
  - In the cycle `mem_rdata` is valid, capture it into the `req_rdata` register and go to DONE.
  - With `RD_LAT=1` this is a single cycle.
- **DONE**
  - `req_ready[g]=1` for exactly one cycle with `req_rdata` valid.
  - Update the round-robin pointer `last=g`, return to IDLE.
  - `req_valid` is ignored in this cycle, so a requester may drop or re-raise it freely.
- **Winner selection**: first requester with `req_valid` set, scanning `last+1, last+2, …` modulo `NREQ`.
- **Writes**
  - Follow the identical path and latency.
  - `req_rdata` on a write completion equals `mem_rdata` (BRAM read-during-write value) and requesters must not rely on it.
- **Protocol violations**: if `req_valid` drops after grant, the access still completes and `req_ready` still pulses. Inputs are not re-sampled after grant.
- **Non-granted requester**: its `req_ready` stays 0 indefinitely. With `NREQ` requesters continuously valid, each one waits at most `NREQ-1` accesses.

## Timing
- **Reset** (`rst_n=0`, async), forced immediately:
  - state=IDLE, `mem_en=0`, `mem_we=0`, `mem_addr=0`, `mem_wdata=0`, `req_ready=0`, `req_rdata=0`, `busy=0`, `grant_id=0`, `last=NREQ-1` (so requester 0 wins first).
  - An in-flight access is abandoned with no `req_ready`.
- **Access latency**: valid sampled in IDLE at cycle T → `mem_en` at T+1 → `req_ready` at T+2+`RD_LAT`.
- **Throughput**: back-to-back accesses every `RD_LAT+3` cycles; the next `mem_en` is at T+4+`RD_LAT` at the earliest.
- **Simultaneous events**: a new `req_valid` arriving during DONE is arbitrated in the following IDLE cycle.
- **Pointer wrap**: `last=NREQ-1` wraps to search from 0.

## Configuration
- `MEM_ARB_PRIO0_EN`:
  - Defined: requester 0 (flash writer) has strict priority and always wins when valid. The remaining requesters round-robin among themselves, and the pointer is not updated on a requester-0 grant.
  - Undefined: pure round-robin over all `NREQ` requesters.

## Structure
- Package `mem_arb_pkg`:
  - state enum `arb_state_t` {IDLE, ISSUE, WAIT, DONE}.
  - `RD_LAT_MAX=3`.
  - function `id_w(n)` returning `$clog2(n)`, minimum 1.
- Sub-module `rr_picker`: purely combinational, taking `NREQ` request bits and the `last` pointer and producing winner index plus `found`. The priority-0 variant is selected under the macro.

## Test plan
- Single read, `RD_LAT=1`: req1 valid at T, addr 0x10, BRAM holds 0xDEADBEEF → `mem_en` at T+1 with `mem_addr=0x10`, `req_ready=3'b010` and `req_rdata=0xDEADBEEF` at T+3.
- Write, wstrb=4'b0011, data 0x12345678, addr 0x20 → `mem_we=4'b0011` at T+1; a later read of 0x20 returns the low half updated.
- All three requesters valid continuously, round-robin build → grant order 0,1,2,0,1,2; `mem_en` spacing 4 cycles.
- Same stimulus with `MEM_ARB_PRIO0_EN`, req0 valid throughout → only req0 served; after it drops, 1 and 2 alternate.
- `RD_LAT=3` → `req_ready` exactly 5 cycles after valid sampled; data matches.
- `rst_n` pulled low during WAIT → all outputs 0 immediately, no `req_ready`; after release, the pending requester is re-served from IDLE.
